// File: rtl/count_display_driver.sv
// count_display_driver
//   Receives the 4-bit counter value from the counter block, brings it into
//   the local clock domain, filters out short glitches, splits it into two
//   decimal digits (00..15) and drives a time-multiplexed 2-digit 7-segment
//   display.
//
// Ports
//   clk  : system clock, all flops on rising edge
//   rs   : asynchronous active-low reset
//   d    : counter value, asynchronous to clk
//   seg  : segment drive {a,b,c,d,e,f,g}, seg[6]=a (registered)
//   an   : digit enable, an[0]=ones, an[1]=tens (registered)
//   val  : currently accepted value, for debug (registered)
//
// Parameters
//   REFRESH_DIV : clk cycles each digit stays enabled (2..2^20)
//   BLANK_LZ    : 1 = blank the tens digit when it is 0
//   ACTIVE_LOW  : 1 = seg/an active-low, 0 = active-high
module count_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [3:0] d,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] val
);

  localparam int       PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  // Inactive levels for the display drive.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  // sync[0] = first flop, sync[1] = second flop
  logic [1:0][3:0]  sync;
  logic [3:0]       s2_prev;
  logic [PW-1:0]    pre;
  logic             sel;

  logic [3:0] tens, ones, digit;
  logic [6:0] pat, seg_nxt;
  logic [1:0] an_nxt;

  // Active-high segment pattern for decimal digits.
  function automatic logic [6:0] seg_pat(input logic [3:0] dg);
    case (dg)
      4'd0:    seg_pat = 7'h7E;
      4'd1:    seg_pat = 7'h30;
      4'd2:    seg_pat = 7'h6D;
      4'd3:    seg_pat = 7'h79;
      4'd4:    seg_pat = 7'h33;
      4'd5:    seg_pat = 7'h5B;
      4'd6:    seg_pat = 7'h5F;
      4'd7:    seg_pat = 7'h70;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h7B;
      default: seg_pat = 7'h00;
    endcase
  endfunction

  // Synchroniser and glitch filter. A value is accepted only once the
  // synchroniser output has matched its previous sample, so a one-cycle
  // excursion on d never reaches val.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      sync    <= '0;
      s2_prev <= '0;
      val     <= '0;
    end else begin
      sync[0] <= d;
      sync[1] <= sync[0];
      s2_prev <= sync[1];
      if (sync[1] == s2_prev && sync[1] != val)
        val <= sync[1];
    end
  end

  // Scan prescaler; sel flips on each wrap.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      pre <= '0;
      sel <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      sel <= ~sel;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Decimal split, 4-bit only (val never exceeds 15).
  always_comb begin
    tens  = {3'b000, (val >= 4'd10)};
    ones  = (val >= 4'd10) ? (val - 4'd10) : val;
    digit = sel ? tens : ones;
    pat   = seg_pat(digit);
    if (sel && tens == 4'd0 && BLANK_LZ)
      pat = 7'h00;
    seg_nxt = ACTIVE_LOW ? ~pat : pat;
    an_nxt  = sel ? 2'b10 : 2'b01;
    if (ACTIVE_LOW)
      an_nxt = ~an_nxt;
  end

  // Output register; the blanked tens slot keeps its enable active.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver. Two instances share stimulus:
// u0 = active-low with leading-zero blanking, u1 = active-high without.
// The reference model works from the decimal value with plain arithmetic
// and derives the scan slot from the number of edges since reset release.
module tb_count_display_driver;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic [3:0] d   = 4'd0;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic [3:0] val0, val1;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // edges since reset release
  int cur   = 0;   // value the display should be showing

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rs(rs), .d(d), .seg(seg0), .an(an0), .val(val0));
  count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rs(rs), .d(d), .seg(seg1), .an(an1), .val(val1));

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pat(input int dg);
    case (dg)
      0: return 7'h7E; 1: return 7'h30; 2: return 7'h6D; 3: return 7'h79;
      4: return 7'h33; 5: return 7'h5B; 6: return 7'h5F; 7: return 7'h70;
      8: return 7'h7F; 9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit s, input bit blank, input bit al);
    int dg;
    logic [6:0] p;
    dg = s ? v / 10 : v % 10;
    p  = (s && (v / 10) == 0 && blank) ? 7'h00 : pat(dg);
    return al ? ~p : p;
  endfunction

  function automatic logic [1:0] exp_an(input bit s, input bit al);
    logic [1:0] a;
    a = s ? 2'b10 : 2'b01;
    return al ? ~a : a;
  endfunction

  // Slot shown after edge n: each digit lasts R edges, ones first.
  function automatic bit sel_now();
    return bit'(((n - 1) / R) % 2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rs) n++;
  endtask

  task automatic chk_an();
    chk("an0", {6'd0, an0}, {6'd0, exp_an(sel_now(), 1'b1)});
    chk("an1", {6'd0, an1}, {6'd0, exp_an(sel_now(), 1'b0)});
  endtask

  task automatic chk_full(input int v);
    chk_an();
    chk("seg0", {1'b0, seg0}, {1'b0, exp_seg(v, sel_now(), 1'b1, 1'b1)});
    chk("seg1", {1'b0, seg1}, {1'b0, exp_seg(v, sel_now(), 1'b0, 1'b0)});
    chk("val0", {4'd0, val0}, 8'(v));
    chk("val1", {4'd0, val1}, 8'(v));
  endtask

  task automatic chk_reset();
    chk("rst_seg0", {1'b0, seg0}, 8'h7F);
    chk("rst_an0",  {6'd0, an0},  8'h03);
    chk("rst_val0", {4'd0, val0}, 8'h00);
    chk("rst_seg1", {1'b0, seg1}, 8'h00);
    chk("rst_an1",  {6'd0, an1},  8'h00);
    chk("rst_val1", {4'd0, val1}, 8'h00);
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      chk_full(cur);
    end
  endtask

  // New value on d: the old value must survive the first two edges, the
  // next three are the acceptance window, after that the new value rules.
  task automatic change(input int v, input int k);
    d = 4'(v);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_full(cur);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_an();
    end
    cur = v;
    hold(k - 5);
  endtask

  // One-cycle excursion on d; nothing downstream may move.
  task automatic glitch(input int g);
    d = 4'(g);
    tick();
    chk_full(cur);
    d = 4'(cur);
    hold(8);
  endtask

  initial begin
    // 1: async reset mid-cycle, then blanked tens of "0"
    tick();
    #2 rs = 1'b0;
    #1 chk_reset();
    tick();
    chk_reset();
    rs = 1'b1;
    n = 0;
    cur = 0;
    tick();
    chk("e1_an0",  {6'd0, an0},  8'h02);
    chk("e1_seg0", {1'b0, seg0}, 8'h01);
    hold(3);
    tick();
    chk("e5_an0",  {6'd0, an0},  8'h01);
    chk("e5_seg0", {1'b0, seg0}, 8'h7F);
    chk_full(cur);
    hold(4);

    // 2, 3: single and double digit values
    change(7, 14);
    change(13, 14);

    // 4: glitch 4 -> 9 -> 4
    change(4, 10);
    glitch(9);

    // 5: sweep every value, both digits visible in each hold
    for (int v = 0; v < 16; v++) change(v, 20);

    // random values and random glitches
    for (int i = 0; i < 30; i++) begin
      change(int'($urandom_range(0, 15)), int'($urandom_range(6, 16)));
      if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(0, 15)));
    end

    // 6: reset while tens slot is up with val=15
    change(15, 10);
    for (int i = 0; i < 2 * R && !sel_now(); i++) hold(1);
    chk("pre_rst_sel", {7'd0, sel_now()}, 8'h01);
    #2 rs = 1'b0;
    #1 chk_reset();
    tick();
    chk_reset();
    rs = 1'b1;
    n = 0;
    cur = 0;
    change(15, 12);
    change(int'($urandom_range(0, 9)), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
